// File: rtl/i2c_slave.sv
// I2C target with an 8-bit register pointer, a write strobe port and a read lookup port.
// Define I2C_SLAVE_GCALL_EN to also accept the general-call address (7'h00, write only).
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       iw_clk,
    input  logic       iw_reset_n,
    inout  wire        io_i2c_scl,
    inout  wire        io_i2c_sda,
    output logic       or_wr_valid,
    output logic [7:0] or_wr_addr,
    output logic [7:0] or_wr_data,
    output logic [7:0] or_rd_addr,
    input  logic [7:0] iw_rd_data,
    output logic       or_busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_WR_PTR,
        ST_ACK_PTR,
        ST_WR_DATA,
        ST_ACK_WR,
        ST_RD_DATA,
        ST_MACK
    } state_t;

    state_t     r_state;
    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       r_sda_oe;
    logic       r_rw;
    logic [3:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_tx;
    logic [7:0] r_rx_data;
    logic [7:0] r_ptr;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_rx_byte;
    logic       w_last_rx_bit;
    logic       w_addr_match;

    always_ff @(posedge iw_clk or negedge iw_reset_n) begin
        if (!iw_reset_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], io_i2c_scl};
            r_sda_sync <= {r_sda_sync[0], io_i2c_sda};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    // Byte as it stands including the bit sampled on the current rising edge
    assign w_rx_byte     = {r_shift, w_sda};
    assign w_last_rx_bit = (r_bit_cnt == 4'd7);

`ifdef I2C_SLAVE_GCALL_EN
    assign w_addr_match = (w_rx_byte[7:1] == SLAVE_ADDR) ||
                          ((w_rx_byte[7:1] == 7'h00) && !w_rx_byte[0]);
`else
    assign w_addr_match = (w_rx_byte[7:1] == SLAVE_ADDR);
`endif

    assign io_i2c_sda = r_sda_oe ? 1'b0 : 1'bz;
    assign or_rd_addr = r_ptr;

    always_ff @(posedge iw_clk or negedge iw_reset_n) begin
        if (!iw_reset_n) begin
            r_state     <= ST_IDLE;
            r_sda_oe    <= 1'b0;
            r_rw        <= 1'b0;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 7'd0;
            r_tx        <= 8'h00;
            r_rx_data   <= 8'h00;
            r_ptr       <= 8'h00;
            or_wr_valid <= 1'b0;
            or_wr_addr  <= 8'h00;
            or_wr_data  <= 8'h00;
            or_busy     <= 1'b0;
        end else begin
            or_wr_valid <= 1'b0;
            if (w_stop) begin
                r_state   <= ST_IDLE;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                or_busy   <= 1'b0;
            end else if (w_start) begin
                r_state   <= ST_ADDR;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                or_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_rx_bit) begin
                                if (w_addr_match) begin
                                    r_state <= ST_ACK_ADDR;
                                    r_rw    <= w_rx_byte[0];
                                    or_busy <= 1'b1;
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end
                        end
                    end
                    // ACK states: first falling edge starts the ACK, the second ends it
                    ST_ACK_ADDR: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else if (r_rw) begin
                                r_tx      <= iw_rd_data;
                                r_sda_oe  <= ~iw_rd_data[7];
                                r_bit_cnt <= 4'd0;
                                r_state   <= ST_RD_DATA;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= ST_WR_PTR;
                            end
                        end
                    end
                    ST_WR_PTR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_rx_bit) begin
                                r_ptr   <= w_rx_byte;
                                r_state <= ST_ACK_PTR;
                            end
                        end
                    end
                    ST_ACK_PTR: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_rx_bit) begin
                                r_rx_data <= w_rx_byte;
                                r_state   <= ST_ACK_WR;
                            end
                        end
                    end
                    ST_ACK_WR: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe    <= 1'b0;
                                or_wr_valid <= 1'b1;
                                or_wr_addr  <= r_ptr;
                                or_wr_data  <= r_rx_data;
                                r_ptr       <= r_ptr + 8'd1;
                                r_bit_cnt   <= 4'd0;
                                r_state     <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_MACK;
                            end else begin
                                r_tx     <= {r_tx[6:0], 1'b0};
                                r_sda_oe <= ~r_tx[6];
                            end
                        end
                    end
                    // NACK parks in IDLE with busy still set until STOP/START
                    ST_MACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_ptr <= r_ptr + 8'd1;
                            end
                        end else if (w_scl_fall) begin
                            r_tx      <= iw_rd_data;
                            r_sda_oe  <= ~iw_rd_data[7];
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_RD_DATA;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged open-drain master with per-scenario checks.
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sclLow = 1'b0;
    logic       sdaLow = 1'b0;
    wire        sclLine;
    wire        sdaLine;
    logic       wrValid;
    logic [7:0] wrAddr;
    logic [7:0] wrData;
    logic [7:0] rdAddr;
    logic [7:0] rdData;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] pulseAddr[$];
    logic [7:0] pulseData[$];

    assign sclLine = sclLow ? 1'b0 : 1'bz;
    assign sdaLine = sdaLow ? 1'b0 : 1'bz;
    pullup (sclLine);
    pullup (sdaLine);

    // Register file model seen by the read port
    assign rdData = 8'h3C + rdAddr;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .iw_clk     (clk),
        .iw_reset_n (resetN),
        .io_i2c_scl (sclLine),
        .io_i2c_sda (sdaLine),
        .or_wr_valid(wrValid),
        .or_wr_addr (wrAddr),
        .or_wr_data (wrData),
        .or_rd_addr (rdAddr),
        .iw_rd_data (rdData),
        .or_busy    (busy)
    );

    always #5 clk = ~clk;

    // Every cycle with the write strobe high records one entry
    always @(negedge clk) begin
        if (wrValid === 1'b1) begin
            pulseAddr.push_back(wrAddr);
            pulseData.push_back(wrData);
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clockBit(input logic b, output logic s);
        sdaLow = ~b;
        waitClk(4);
        sclLow = 1'b0;
        waitClk(4);
        s = sdaLine;
        waitClk(4);
        sclLow = 1'b1;
        waitClk(4);
    endtask

    task automatic startCond();
        sdaLow = 1'b0;
        waitClk(4);
        sclLow = 1'b0;
        waitClk(8);
        sdaLow = 1'b1;
        waitClk(8);
        sclLow = 1'b1;
        waitClk(4);
    endtask

    task automatic stopCond();
        sdaLow = 1'b1;
        waitClk(4);
        sclLow = 1'b0;
        waitClk(8);
        sdaLow = 1'b0;
        waitClk(8);
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(b[i], s);
        clockBit(1'b1, s);
        ack = ~s;
    endtask

    task automatic readByte(input logic mAck, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clockBit(1'b1, s);
            d[i] = s;
        end
        clockBit(~mAck, s);
    endtask

    task automatic clearPulses();
        pulseAddr.delete();
        pulseData.delete();
    endtask

    task automatic test_reset();
        waitClk(3);
        compared++; if (sdaLine !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_sda: got %b want 1", sdaLine); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        compared++; if (wrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wr_valid: got %b want 0", wrValid); end
        compared++; if (wrAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_wr_addr: got %h want 00", wrAddr); end
        compared++; if (wrData !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_wr_data: got %h want 00", wrData); end
        compared++; if (rdAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rd_addr: got %h want 00", rdAddr); end
        resetN = 1'b1;
        waitClk(4);
    endtask

    task automatic test_write_single();
        logic a0, a1, a2;
        clearPulses();
        startCond();
        sendByte(8'hA0, a0);
        sendByte(8'h10, a1);
        sendByte(8'h5A, a2);
        compared++; if (a0 !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_ack_addr: got %b want 1", a0); end
        compared++; if (a1 !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_ack_ptr: got %b want 1", a1); end
        compared++; if (a2 !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_ack_data: got %b want 1", a2); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_busy_active: got %b want 1", busy); end
        stopCond();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_busy_stop: got %b want 0", busy); end
        compared++; if (pulseAddr.size() !== 1) begin mismatched++; $display("[TB] FAIL wr_pulse_count: got %0d want 1", pulseAddr.size()); end
        compared++; if ((pulseAddr.size() > 0 ? pulseAddr[0] : 8'hxx) !== 8'h10) begin mismatched++; $display("[TB] FAIL wr_pulse_addr: got %h want 10", pulseAddr.size() > 0 ? pulseAddr[0] : 8'hxx); end
        compared++; if ((pulseData.size() > 0 ? pulseData[0] : 8'hxx) !== 8'h5A) begin mismatched++; $display("[TB] FAIL wr_pulse_data: got %h want 5a", pulseData.size() > 0 ? pulseData[0] : 8'hxx); end
        compared++; if (rdAddr !== 8'h11) begin mismatched++; $display("[TB] FAIL wr_ptr_incr: got %h want 11", rdAddr); end
    endtask

    task automatic test_ptr_wrap();
        logic a;
        clearPulses();
        startCond();
        sendByte(8'hA0, a);
        sendByte(8'hFF, a);
        sendByte(8'h01, a);
        sendByte(8'h02, a);
        stopCond();
        compared++; if (pulseAddr.size() !== 2) begin mismatched++; $display("[TB] FAIL wrap_pulse_count: got %0d want 2", pulseAddr.size()); end
        compared++; if ((pulseAddr.size() > 0 ? pulseAddr[0] : 8'hxx) !== 8'hFF) begin mismatched++; $display("[TB] FAIL wrap_addr0: got %h want ff", pulseAddr.size() > 0 ? pulseAddr[0] : 8'hxx); end
        compared++; if ((pulseData.size() > 0 ? pulseData[0] : 8'hxx) !== 8'h01) begin mismatched++; $display("[TB] FAIL wrap_data0: got %h want 01", pulseData.size() > 0 ? pulseData[0] : 8'hxx); end
        compared++; if ((pulseAddr.size() > 1 ? pulseAddr[1] : 8'hxx) !== 8'h00) begin mismatched++; $display("[TB] FAIL wrap_addr1: got %h want 00", pulseAddr.size() > 1 ? pulseAddr[1] : 8'hxx); end
        compared++; if ((pulseData.size() > 1 ? pulseData[1] : 8'hxx) !== 8'h02) begin mismatched++; $display("[TB] FAIL wrap_data1: got %h want 02", pulseData.size() > 1 ? pulseData[1] : 8'hxx); end
    endtask

    task automatic test_read_repstart();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        clearPulses();
        startCond();
        sendByte(8'hA0, a0);
        sendByte(8'h04, a1);
        startCond();
        sendByte(8'hA1, a2);
        compared++; if (a2 !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_ack_addr: got %b want 1", a2); end
        readByte(1'b1, d0);
        readByte(1'b0, d1);
        compared++; if (d0 !== 8'h40) begin mismatched++; $display("[TB] FAIL rd_byte0: got %h want 40", d0); end
        compared++; if (d1 !== 8'h41) begin mismatched++; $display("[TB] FAIL rd_byte1: got %h want 41", d1); end
        waitClk(4);
        compared++; if (sdaLine !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_sda_after_nack: got %b want 1", sdaLine); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_busy_after_nack: got %b want 1", busy); end
        compared++; if (rdAddr !== 8'h05) begin mismatched++; $display("[TB] FAIL rd_ptr_after_nack: got %h want 05", rdAddr); end
        stopCond();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_busy_stop: got %b want 0", busy); end
        compared++; if (pulseAddr.size() !== 0) begin mismatched++; $display("[TB] FAIL rd_no_pulse: got %0d want 0", pulseAddr.size()); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1, a2, ag;
        logic expGcall;
        clearPulses();
        startCond();
        sendByte(8'hA2, a0);
        compared++; if (a0 !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_ack: got %b want 0", a0); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_busy: got %b want 0", busy); end
        sendByte(8'h33, a1);
        sendByte(8'h44, a2);
        compared++; if ({a1, a2} !== 2'b00) begin mismatched++; $display("[TB] FAIL miss_ignored_acks: got %b want 00", {a1, a2}); end
        stopCond();
        compared++; if (pulseAddr.size() !== 0) begin mismatched++; $display("[TB] FAIL miss_no_pulse: got %0d want 0", pulseAddr.size()); end
`ifdef I2C_SLAVE_GCALL_EN
        expGcall = 1'b1;
`else
        expGcall = 1'b0;
`endif
        startCond();
        sendByte(8'h00, ag);
        stopCond();
        compared++; if (ag !== expGcall) begin mismatched++; $display("[TB] FAIL gcall_ack: got %b want %b", ag, expGcall); end
    endtask

    task automatic test_stop_midbyte();
        logic a, s;
        clearPulses();
        startCond();
        sendByte(8'hA0, a);
        sendByte(8'h20, a);
        clockBit(1'b1, s);
        clockBit(1'b0, s);
        clockBit(1'b1, s);
        clockBit(1'b1, s);
        stopCond();
        waitClk(4);
        compared++; if (pulseAddr.size() !== 0) begin mismatched++; $display("[TB] FAIL midstop_no_pulse: got %0d want 0", pulseAddr.size()); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midstop_busy: got %b want 0", busy); end
        compared++; if (sdaLine !== 1'b1) begin mismatched++; $display("[TB] FAIL midstop_sda: got %b want 1", sdaLine); end
        compared++; if (rdAddr !== 8'h20) begin mismatched++; $display("[TB] FAIL midstop_ptr: got %h want 20", rdAddr); end
    endtask

    task automatic test_reset_midread();
        logic a, a1, a2;
        logic [7:0] d;
        clearPulses();
        startCond();
        sendByte(8'hA0, a);
        sendByte(8'h08, a);
        startCond();
        sendByte(8'hA1, a);
        compared++; if (sdaLine !== 1'b0) begin mismatched++; $display("[TB] FAIL rstrd_msb_driven: got %b want 0", sdaLine); end
        @(negedge clk);
        resetN = 1'b0;
        #1;
        compared++; if (sdaLine !== 1'b1) begin mismatched++; $display("[TB] FAIL rstrd_sda: got %b want 1", sdaLine); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rstrd_busy: got %b want 0", busy); end
        compared++; if (rdAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL rstrd_rd_addr: got %h want 00", rdAddr); end
        compared++; if (wrData !== 8'h00) begin mismatched++; $display("[TB] FAIL rstrd_wr_data: got %h want 00", wrData); end
        compared++; if (wrAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL rstrd_wr_addr: got %h want 00", wrAddr); end
        @(negedge clk);
        resetN = 1'b1;
        readByte(1'b0, d);
        compared++; if (d !== 8'hFF) begin mismatched++; $display("[TB] FAIL rstrd_bus_ignored: got %h want ff", d); end
        stopCond();
        startCond();
        sendByte(8'hA0, a);
        sendByte(8'h30, a1);
        sendByte(8'h77, a2);
        stopCond();
        compared++; if ({a, a1, a2} !== 3'b111) begin mismatched++; $display("[TB] FAIL rstrd_new_acks: got %b want 111", {a, a1, a2}); end
        compared++; if (pulseAddr.size() !== 1) begin mismatched++; $display("[TB] FAIL rstrd_pulse_count: got %0d want 1", pulseAddr.size()); end
        compared++; if ((pulseAddr.size() > 0 ? pulseAddr[0] : 8'hxx) !== 8'h30) begin mismatched++; $display("[TB] FAIL rstrd_pulse_addr: got %h want 30", pulseAddr.size() > 0 ? pulseAddr[0] : 8'hxx); end
        compared++; if ((pulseData.size() > 0 ? pulseData[0] : 8'hxx) !== 8'h77) begin mismatched++; $display("[TB] FAIL rstrd_pulse_data: got %h want 77", pulseData.size() > 0 ? pulseData[0] : 8'hxx); end
    endtask

    initial begin
        $display("[TB] i2c_slave directed bench starting");
        test_reset();
        test_write_single();
        test_ptr_wrap();
        test_read_repstart();
        test_addr_mismatch();
        test_stop_midbyte();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
